// File: rtl/cam_gen_pkg.sv
// -----------------------------------------------------------------------------
// cam_gen_pkg
// Shared definitions for the camera pattern generator:
//   state_e    - frame FSM states
//   MODE_*     - pattern mode encodings driven on the 'mode' input
//   BAR_COLOR  - RGB565 colour-bar palette, leftmost bar first
// -----------------------------------------------------------------------------
package cam_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBP,
        LINE,
        HBLANK,
        VFP
    } state_e;

    localparam logic [1:0] MODE_RAMP  = 2'd0;
    localparam logic [1:0] MODE_BARS  = 2'd1;
    localparam logic [1:0] MODE_SOLID = 2'd2;
    localparam logic [1:0] MODE_BALL  = 2'd3;

    localparam logic [15:0] BAR_COLOR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

endpackage

// File: rtl/cam_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen_if
// OV7670-style parallel video bus.
//   pclk  - pixel clock (receiver samples on rising edge)
//   vsync - frame sync, active high
//   href  - line valid, active high
//   data  - pixel byte, RGB565 high byte first
// master: the camera/source side; slave: the capture side.
// -----------------------------------------------------------------------------
interface cam_pattern_gen_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] data;

    modport master (output pclk, vsync, href, data);
    modport slave  (input  pclk, vsync, href, data);
endinterface

// File: rtl/cam_pclk_div.sv
// -----------------------------------------------------------------------------
// cam_pclk_div
// Divides inclk down to the registered pixel clock and flags the inclk cycle
// in which pclk is about to be registered 1->0 (the "fall tick").
//   inclk_i     - system clock
//   res_i       - synchronous active-low reset (pclk returns to 1)
//   pclk_o      - pixel clock, toggles every PCLK_DIV/2 inclk cycles
//   fall_tick_o - high in the cycle whose closing edge drives pclk low
// -----------------------------------------------------------------------------
module cam_pclk_div #(
    parameter int PCLK_DIV = 16
) (
    input  logic inclk_i,
    input  logic res_i,
    output logic pclk_o,
    output logic fall_tick_o
);
    localparam int HALF = PCLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DW-1:0] cnt_q, cnt_d;
    logic          pclk_q, pclk_d;
    logic          wrap;

    assign wrap = (cnt_q == DW'(HALF - 1));

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        pclk_d = wrap ? ~pclk_q : pclk_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge inclk_i) begin
        if (!res_i) begin
            cnt_q  <= '0;
            pclk_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign pclk_o      = pclk_q;
    assign fall_tick_o = wrap & pclk_q;
endmodule

// File: rtl/cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// cam_pattern_gen
// Synthesizable camera source emitting OV7670-style video with programmable
// timing and test patterns (ramp, colour bars, solid, square ball).
//   inclk, res          - system clock, synchronous active-low reset
//   enable              - run frames back to back while high
//   mode                - pattern select (see cam_gen_pkg MODE_*)
//   color, ball_color   - RGB565 background / ball colour
//   ball_x/_y/_size     - ball top-left pixel/line and side length
//   cam (master)        - pclk/vsync/href/data video bus
//   frame_done          - one-inclk pulse on the last VFP fall tick
//   busy                - high whenever a frame is in progress
// All state and video outputs move only on the pclk fall tick, so they are
// settled half a pclk period before the receiver's rising-edge sample.
// -----------------------------------------------------------------------------
module cam_pattern_gen
    import cam_gen_pkg::*;
#(
    parameter int PCLK_DIV   = 16,
    parameter int H_ACTIVE   = 640,
    parameter int H_BLANK    = 144,
    parameter int V_ACTIVE   = 480,
    parameter int VSYNC_PCLK = 320,
    parameter int VBP_PCLK   = 960,
    parameter int VFP_PCLK   = 3200
) (
    input  logic              inclk,
    input  logic              res,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [15:0]       color,
    input  logic [15:0]       ball_color,
    input  logic [9:0]        ball_x,
    input  logic [8:0]        ball_y,
    input  logic [7:0]        ball_size,
    cam_pattern_gen_if.master cam,
    output logic              frame_done,
    output logic              busy
);
    localparam int CNT_W = 16;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    logic pclk, fall_tick;

    cam_pclk_div #(.PCLK_DIV(PCLK_DIV)) u_pclk_div (
        .inclk_i     (inclk),
        .res_i       (res),
        .pclk_o      (pclk),
        .fall_tick_o (fall_tick)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, len_m1;
    logic [8:0]       line_q, line_d;
    logic             latch, last;

    logic [1:0]  mode_q;
    logic [15:0] color_q, ball_color_q;
    logic [9:0]  ball_x_q;
    logic [8:0]  ball_y_q;
    logic [7:0]  ball_size_q;

    logic       vsync_q, href_q, frame_done_q, frame_done_d;
    logic [7:0] data_q, data_d;

    // Length of the current state in pclk periods, minus one.
    always_comb begin
        case (state_q)
            VSYNC:   len_m1 = CNT_W'(VSYNC_PCLK - 1);
            VBP:     len_m1 = CNT_W'(VBP_PCLK - 1);
            LINE:    len_m1 = CNT_W'(2 * H_ACTIVE - 1);
            HBLANK:  len_m1 = CNT_W'(2 * H_BLANK - 1);
            VFP:     len_m1 = CNT_W'(VFP_PCLK - 1);
            default: len_m1 = '0;
        endcase
    end

    assign last = (cnt_q == len_m1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        latch        = 1'b0;
        frame_done_d = 1'b0;
        if (fall_tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (enable) begin
                        state_d = VSYNC;
                        latch   = 1'b1;
                    end
                end
                VSYNC: if (last) begin
                    state_d = VBP;
                    cnt_d   = '0;
                end
                VBP: if (last) begin
                    state_d = LINE;
                    cnt_d   = '0;
                    line_d  = '0;
                end
                LINE: if (last) begin
                    state_d = HBLANK;
                    cnt_d   = '0;
                end
                HBLANK: if (last) begin
                    cnt_d = '0;
                    if (line_q == 9'(V_ACTIVE - 1)) begin
                        state_d = VFP;
                    end else begin
                        state_d = LINE;
                        line_d  = line_q + 1'b1;
                    end
                end
                VFP: if (last) begin
                    cnt_d        = '0;
                    frame_done_d = 1'b1;
                    if (enable) begin
                        state_d = VSYNC;
                        latch   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pattern for the byte that will be on the bus after this edge. In LINE
    // the state counter is the byte index within the line.
    logic [10:0] byte_idx, px_x;
    logic [2:0]  bar_idx;
    logic        in_ball;
    logic [15:0] pixel;

    always_comb begin
        byte_idx = cnt_d[10:0];
        px_x     = {1'b0, byte_idx[10:1]};
        bar_idx  = 3'(px_x / 11'(BAR_W));
        // Widened sums so a ball near the frame edge never wraps back to 0.
        in_ball  = (px_x >= {1'b0, ball_x_q})
                && (px_x < ({1'b0, ball_x_q} + {3'b0, ball_size_q}))
                && ({1'b0, line_d} >= {1'b0, ball_y_q})
                && ({1'b0, line_d} < ({1'b0, ball_y_q} + {2'b0, ball_size_q}));
        pixel = 16'h0000;
        case (mode_q)
            MODE_BARS:  pixel = BAR_COLOR[bar_idx];
            MODE_SOLID: pixel = color_q;
            MODE_BALL:  pixel = in_ball ? ball_color_q : color_q;
            default:    pixel = 16'h0000;
        endcase
        data_d = 8'h00;
        if (state_d == LINE) begin
            if (mode_q == MODE_RAMP) data_d = byte_idx[7:0];
            else                     data_d = byte_idx[0] ? pixel[7:0] : pixel[15:8];
        end
    end

    always_ff @(posedge inclk) begin
        if (!res) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            mode_q       <= MODE_RAMP;
            color_q      <= '0;
            ball_color_q <= '0;
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            ball_size_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            vsync_q      <= (state_d == VSYNC);
            href_q       <= (state_d == LINE);
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            // Frame configuration is frozen at VSYNC entry.
            if (latch) begin
                mode_q       <= mode;
                color_q      <= color;
                ball_color_q <= ball_color;
                ball_x_q     <= ball_x;
                ball_y_q     <= ball_y;
                ball_size_q  <= ball_size;
            end
        end
    end

    assign cam.pclk   = pclk;
    assign cam.vsync  = vsync_q;
    assign cam.href   = href_q;
    assign cam.data   = data_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_cam_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_cam_pattern_gen
// Scoreboard bench for cam_pattern_gen with small frame parameters. Stimulus
// pushes the expected per-pclk-period bus contents of each frame it starts;
// a monitor pops one entry per pclk rise. Between frames the monitor expects
// an idle bus.
// -----------------------------------------------------------------------------
module tb_cam_pattern_gen;
    localparam int PCLK_DIV   = 4;
    localparam int H_ACTIVE   = 16;
    localparam int H_BLANK    = 4;
    localparam int V_ACTIVE   = 4;
    localparam int VSYNC_PCLK = 2;
    localparam int VBP_PCLK   = 3;
    localparam int VFP_PCLK   = 5;
    localparam int FRAME_PCLK = VSYNC_PCLK + VBP_PCLK
                              + V_ACTIVE * 2 * (H_ACTIVE + H_BLANK) + VFP_PCLK;

    localparam logic [15:0] BARS [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    logic        inclk = 1'b0;
    logic        res = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [15:0] color = 16'h0;
    logic [15:0] ball_color = 16'h0;
    logic [9:0]  ball_x = 10'd0;
    logic [8:0]  ball_y = 9'd0;
    logic [7:0]  ball_size = 8'd0;
    logic        frame_done, busy;

    cam_pattern_gen_if cam ();

    cam_pattern_gen #(
        .PCLK_DIV(PCLK_DIV), .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK),
        .V_ACTIVE(V_ACTIVE), .VSYNC_PCLK(VSYNC_PCLK), .VBP_PCLK(VBP_PCLK),
        .VFP_PCLK(VFP_PCLK)
    ) dut (
        .inclk(inclk), .res(res), .enable(enable), .mode(mode),
        .color(color), .ball_color(ball_color), .ball_x(ball_x),
        .ball_y(ball_y), .ball_size(ball_size), .cam(cam.master),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 inclk = ~inclk;

    typedef struct {
        logic       vs;
        logic       hr;
        logic [7:0] d;
        int         done;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] color;
        logic [15:0] ball_color;
        int          bx;
        int          by;
        int          bs;
    } cfg_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   frames_pushed = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: byte b (0-based) of active line y, straight from the pattern rules.
    function automatic logic [7:0] model_byte(input cfg_t c, input int y, input int b);
        int x;
        logic [15:0] pix;
        x = b / 2;
        case (c.mode)
            2'd0:    return 8'(b % 256);
            2'd1:    pix = BARS[x / (H_ACTIVE / 8)];
            2'd2:    pix = c.color;
            default: pix = (x >= c.bx && x < c.bx + c.bs && y >= c.by && y < c.by + c.bs)
                           ? c.ball_color : c.color;
        endcase
        return (b % 2 == 0) ? pix[15:8] : pix[7:0];
    endfunction

    task automatic push_frame(input cfg_t c);
        exp_t e;
        e.done = frames_pushed;
        e.vs = 1'b1; e.hr = 1'b0; e.d = 8'h00;
        repeat (VSYNC_PCLK) exp_q.push_back(e);
        e.vs = 1'b0;
        repeat (VBP_PCLK) exp_q.push_back(e);
        for (int y = 0; y < V_ACTIVE; y++) begin
            for (int b = 0; b < 2 * H_ACTIVE; b++) begin
                e.hr = 1'b1;
                e.d  = model_byte(c, y, b);
                exp_q.push_back(e);
            end
            e.hr = 1'b0; e.d = 8'h00;
            repeat (2 * H_BLANK) exp_q.push_back(e);
        end
        repeat (VFP_PCLK) exp_q.push_back(e);
        frames_pushed++;
    endtask

    // Monitor: one comparison set per pclk rise.
    initial begin
        exp_t e;
        forever begin
            @(posedge cam.pclk);
            #1;
            if (res) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("frame bus {busy,vsync,href,data}",
                          {busy, cam.vsync, cam.href, cam.data}, {1'b1, e.vs, e.hr, e.d});
                    check("frame_done count in frame", done_cnt, e.done);
                end else begin
                    check("idle bus {busy,vsync,href,data}",
                          {busy, cam.vsync, cam.href, cam.data}, 0);
                    check("frame_done count idle", done_cnt, frames_pushed);
                end
            end
        end
    end

    // frame_done pulse counter (counts high cycles, so a stretched pulse shows).
    initial forever begin
        @(posedge inclk);
        #1;
        if (!res) done_cnt = 0;
        else if (frame_done) done_cnt++;
    end

    // pclk half period must always be PCLK_DIV/2 inclk cycles.
    initial begin
        int   since;
        logic pclk_prev;
        since = 0;
        pclk_prev = 1'b1;
        forever begin
            @(posedge inclk);
            #1;
            if (!res) begin
                since = 0;
            end else begin
                since++;
                if (cam.pclk !== pclk_prev) begin
                    check("pclk half period", since, PCLK_DIV / 2);
                    since = 0;
                end
            end
            pclk_prev = cam.pclk;
        end
    end

    task automatic wait_pclk_rise(output bit ok);
        logic prev;
        ok = 1'b0;
        prev = cam.pclk;
        for (int i = 0; i < 4 * PCLK_DIV; i++) begin
            @(posedge inclk);
            #1;
            if (cam.pclk && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = cam.pclk;
        end
    endtask

    task automatic start_frame(input cfg_t c);
        bit ok;
        wait_pclk_rise(ok);
        check("pclk rise before start", int'(ok), 1);
        @(negedge inclk);
        mode = c.mode; color = c.color; ball_color = c.ball_color;
        ball_x = 10'(c.bx); ball_y = 9'(c.by); ball_size = 8'(c.bs);
        enable = 1'b1;
        push_frame(c);
    endtask

    // Drop enable after VSYNC entry and scramble inputs to prove they were latched.
    task automatic end_pulse();
        repeat (6) @(negedge inclk);
        enable = 1'b0;
        mode = 2'($urandom); color = 16'($urandom); ball_color = 16'($urandom);
        ball_x = 10'($urandom); ball_y = 9'($urandom); ball_size = 8'($urandom);
    endtask

    task automatic wait_queue_le(input int n, input string name);
        int i;
        i = 0;
        while (exp_q.size() > n && i < 8000) begin
            @(negedge inclk);
            i++;
        end
        check({name, " progress"}, int'(exp_q.size() <= n), 1);
    endtask

    task automatic wait_empty(input string name);
        wait_queue_le(0, name);
        exp_q.delete();
        repeat (4 * PCLK_DIV) @(negedge inclk);
    endtask

    initial begin
        cfg_t c, c2;

        // Reset and idle.
        repeat (5) @(negedge inclk);
        check("reset pclk", int'(cam.pclk), 1);
        check("reset {vsync,href,data}", {cam.vsync, cam.href, cam.data}, 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset busy", int'(busy), 0);
        res = 1'b1;
        repeat (20) @(negedge inclk);

        // Ramp frame.
        c = '{mode: 2'd0, color: 16'h1234, ball_color: 16'h0, bx: 0, by: 0, bs: 0};
        start_frame(c); end_pulse(); wait_empty("ramp frame");

        // Colour bars.
        c.mode = 2'd1;
        start_frame(c); end_pulse(); wait_empty("bars frame");

        // Ball at (3,1), side 2.
        c = '{mode: 2'd3, color: 16'h0000, ball_color: 16'hF800, bx: 3, by: 1, bs: 2};
        start_frame(c); end_pulse(); wait_empty("ball frame");

        // Continuous: solid frame, mode switched to ramp mid-frame, back-to-back next frame.
        c  = '{mode: 2'd2, color: 16'($urandom), ball_color: 16'h0, bx: 0, by: 0, bs: 0};
        c2 = c; c2.mode = 2'd0;
        start_frame(c);
        push_frame(c2);
        repeat (20) @(negedge inclk);
        mode = 2'd0; color = 16'($urandom);
        wait_queue_le(FRAME_PCLK - 10, "second continuous frame");
        enable = 1'b0;
        wait_empty("continuous frames");

        // Randomized frames.
        for (int k = 0; k < 5; k++) begin
            c.mode       = 2'($urandom_range(0, 3));
            c.color      = 16'($urandom);
            c.ball_color = 16'($urandom);
            c.bx = (k == 4) ? 1020 : $urandom_range(0, 18);
            c.by = $urandom_range(0, 5);
            c.bs = (k == 4) ? 255 : $urandom_range(0, 6);
            start_frame(c); end_pulse(); wait_empty("random frame");
        end

        // Reset mid-line, then a clean frame.
        c = '{mode: 2'd0, color: 16'h0, ball_color: 16'h0, bx: 0, by: 0, bs: 0};
        start_frame(c);
        wait_queue_le(FRAME_PCLK - 20, "frame before mid-line reset");
        @(negedge inclk);
        res = 1'b0;
        @(posedge inclk);
        #1;
        check("mid-line reset pclk", int'(cam.pclk), 1);
        check("mid-line reset {vsync,href,data}", {cam.vsync, cam.href, cam.data}, 0);
        check("mid-line reset busy", int'(busy), 0);
        exp_q.delete();
        frames_pushed = 0;
        enable = 1'b0;
        repeat (3) @(negedge inclk);
        res = 1'b1;
        start_frame(c); end_pulse(); wait_empty("frame after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
